// File: rtl/bb8_pkg.sv
// Shared types for the drive path: ControlLoop -> speed_ramp -> MotorDriver.
package bb8_pkg;

  typedef logic signed [9:0] speed_t;
  typedef logic        [9:0] mag_t;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    DWELL
  } ramp_state_e;

  // |t| limited to max_speed. The absolute value is formed at 11 bits so
  // that -512 becomes +512 instead of wrapping back to -512.
  function automatic mag_t clamp_mag(input speed_t t, input mag_t max_speed);
    logic [10:0] wide;
    logic [10:0] mag;
    wide = {t[9], t};
    mag  = t[9] ? (~wide + 11'd1) : wide;
    return (mag > {1'b0, max_speed}) ? max_speed : mag[9:0];
  endfunction

  // One step toward zero, saturating at zero.
  function automatic mag_t step_down(input mag_t cur, input mag_t step);
    return (cur > step) ? (cur - step) : '0;
  endfunction

  // One step toward goal, landing exactly on it instead of overshooting.
  function automatic mag_t step_toward(input mag_t cur, input mag_t goal,
                                       input mag_t step);
    if (cur < goal)
      return ((goal - cur) > step) ? (cur + step) : goal;
    else
      return ((cur - goal) > step) ? (cur - step) : goal;
  endfunction

endpackage

// File: rtl/speed_ramp_if.sv
// Command/status bundle between the control loop and one wheel's speed_ramp.
interface speed_ramp_if;
  import bb8_pkg::*;

  logic   enable;
  speed_t target_speed;
  mag_t   speed;
  logic   dir;
  logic   at_target;
  logic   reversing;

  // Control loop side: issues the request, watches the shaped command.
  modport master (
    output enable, target_speed,
    input  speed, dir, at_target, reversing
  );

  // Ramp side: consumes the request, produces the shaped command.
  modport slave (
    input  enable, target_speed,
    output speed, dir, at_target, reversing
  );
endinterface

// File: rtl/speed_ramp_tick_gen.sv
// Free-running divider: one-cycle tick on the last count of every DIV cycles.
// Also used for the MPU sample tick, so it stays independent of speed_ramp.
module tick_gen #(
  parameter int unsigned DIV = 100000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..DIV-1 and wrap; synchronous active-low reset.
  // NOTE: registers are written with <= so every flop samples pre-edge values; = here would race between blocks.
  always_ff @(posedge clock) begin
    if (!reset_n)
      cnt <= '0;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/speed_ramp.sv
// Acceleration-limited speed shaper for one wheel. Clamps the signed target,
// slews the magnitude by at most STEP per tick, and forces a zero-speed dwell
// before any direction change. speed/dir feed MotorDriver directly.
module speed_ramp
  import bb8_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned STEP        = 4,
  parameter int unsigned MAX_SPEED   = 400,
  parameter int unsigned DWELL_TICKS = 2
) (
  input  logic clock,
  input  logic reset_n,
  speed_ramp_if.slave bus
);

  localparam mag_t       STEP_M  = mag_t'(STEP);
  localparam mag_t       MAX_M   = mag_t'(MAX_SPEED);
  localparam logic [7:0] DWELL_M = 8'(DWELL_TICKS);

  logic        tick;
  ramp_state_e state_q;
  mag_t        speed_q;
  logic        dir_q;
  logic        at_target_q;
  logic        reversing_q;
  logic [7:0]  dwell_q;

  mag_t        tmag;
  logic        tdir;
  logic        reverse_req;
  mag_t        ramp_down;
  mag_t        ramp_to;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Clamped target and the two candidate next magnitudes.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    tmag        = clamp_mag(bus.target_speed, MAX_M);
    tdir        = ~bus.target_speed[9];
    // A zero target never asks for a reversal; it just ramps to 0.
    reverse_req = (tmag != '0) && (tdir != dir_q);
    ramp_down   = step_down(speed_q, STEP_M);
    ramp_to     = step_toward(speed_q, tmag, STEP_M);
  end

  // Ramp FSM; all state and outputs move only in the tick cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      speed_q     <= '0;
      dir_q       <= 1'b1;
      at_target_q <= 1'b0;
      reversing_q <= 1'b0;
      dwell_q     <= '0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          speed_q     <= '0;
          reversing_q <= 1'b0;
          at_target_q <= 1'b0;
          if (bus.enable) begin
            state_q     <= TRACK;
            // Speed is 0 after this tick, so only a zero target is met.
            at_target_q <= (tmag == '0);
          end
        end

        TRACK: begin
          if (!bus.enable) begin
            // Disable wins over a pending reversal: no dwell on the way down.
            speed_q     <= ramp_down;
            at_target_q <= 1'b0;
            if (ramp_down == '0)
              state_q <= IDLE;
          end else if (reverse_req) begin
            speed_q     <= ramp_down;
            at_target_q <= 1'b0;
            if (ramp_down == '0) begin
              state_q     <= DWELL;
              dwell_q     <= DWELL_M;
              reversing_q <= 1'b1;
            end
          end else begin
            speed_q     <= ramp_to;
            at_target_q <= (ramp_to == tmag);
          end
        end

        DWELL: begin
          speed_q <= '0;
          if (!bus.enable || (tmag == '0) || (tdir == dir_q)) begin
            // Reversal no longer wanted: resume tracking in the old direction.
            state_q     <= TRACK;
            reversing_q <= 1'b0;
            dwell_q     <= '0;
            at_target_q <= bus.enable && (tmag == '0);
          end else if (dwell_q == 8'd1) begin
            // Last dwell tick: flip direction, ramp up from the next tick.
            state_q     <= TRACK;
            dir_q       <= tdir;
            reversing_q <= 1'b0;
            dwell_q     <= '0;
            at_target_q <= 1'b0;
          end else begin
            dwell_q     <= dwell_q - 8'd1;
            at_target_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          speed_q     <= '0;
          reversing_q <= 1'b0;
          at_target_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.speed     = speed_q;
  assign bus.dir       = dir_q;
  assign bus.at_target = at_target_q;
  assign bus.reversing = reversing_q;

endmodule

// File: tb/tb_speed_ramp.sv
// Directed bench for speed_ramp: ramping, no-overshoot, reversal with dwell,
// clamping (second instance with STEP=100), enable drop, and mid-ramp reset.
module tb_speed_ramp;
  import bb8_pkg::*;

  localparam int unsigned TDIV = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  speed_ramp_if bus_a ();
  speed_ramp_if bus_b ();

  speed_ramp #(.TICK_DIV(TDIV), .STEP(4), .MAX_SPEED(400), .DWELL_TICKS(2)) dut_a (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  speed_ramp #(.TICK_DIV(TDIV), .STEP(100), .MAX_SPEED(400), .DWELL_TICKS(2)) dut_b (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance to 1 time unit after the next output-update edge.
  task automatic next_tick();
    repeat (TDIV) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input bit on_b, input int spd,
                           input int d, input int at, input int rev);
    if (on_b) begin
      check({tag, ".speed"},     int'(bus_b.speed),     spd);
      check({tag, ".dir"},       int'(bus_b.dir),       d);
      check({tag, ".at_target"}, int'(bus_b.at_target), at);
      check({tag, ".reversing"}, int'(bus_b.reversing), rev);
    end else begin
      check({tag, ".speed"},     int'(bus_a.speed),     spd);
      check({tag, ".dir"},       int'(bus_a.dir),       d);
      check({tag, ".at_target"}, int'(bus_a.at_target), at);
      check({tag, ".reversing"}, int'(bus_a.reversing), rev);
    end
  endtask

  task automatic step(input string tag, input bit on_b, input int spd,
                      input int d, input int at, input int rev);
    next_tick();
    check_out(tag, on_b, spd, d, at, rev);
  endtask

  initial begin
    reset_n            = 1'b0;
    bus_a.enable       = 1'b0;
    bus_a.target_speed = '0;
    bus_b.enable       = 1'b0;
    bus_b.target_speed = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_a", 1'b0, 0, 1, 0, 0);
    check_out("reset_b", 1'b1, 0, 1, 0, 0);
    reset_n = 1'b1;

    // Clamp on the STEP=100 instance: +500 caps at 400.
    bus_b.enable       = 1'b1;
    bus_b.target_speed = 10'sd500;
    step("b_start", 1'b1, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) step("b_up", 1'b1, 100 * k, 1, (k == 4) ? 1 : 0, 0);
    step("b_hold", 1'b1, 400, 1, 1, 0);
    // -512 clamps to 400 reverse without overflow.
    bus_b.target_speed = -10'sd512;
    for (int k = 1; k <= 3; k++) step("b_down", 1'b1, 400 - 100 * k, 1, 0, 0);
    step("b_zero", 1'b1, 0, 1, 0, 1);
    step("b_dwell", 1'b1, 0, 1, 0, 1);
    step("b_flip", 1'b1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step("b_rev_up", 1'b1, 100 * k, 0, (k == 4) ? 1 : 0, 0);
    step("b_rev_hold", 1'b1, 400, 0, 1, 0);
    bus_b.enable = 1'b0;

    // Ramp to +20, with a between-tick stability probe.
    bus_a.enable       = 1'b1;
    bus_a.target_speed = 10'sd20;
    step("a_start", 1'b0, 0, 1, 0, 0);
    step("a_up1", 1'b0, 4, 1, 0, 0);
    repeat (TDIV / 2) @(posedge clk);
    #1;
    check("a_stable.speed", int'(bus_a.speed), 4);
    repeat (TDIV / 2) @(posedge clk);
    #1;
    check_out("a_up2", 1'b0, 8, 1, 0, 0);
    for (int k = 3; k <= 5; k++) step("a_up", 1'b0, 4 * k, 1, (k == 5) ? 1 : 0, 0);

    // Back to rest, then +10 with no overshoot and a steady hold.
    bus_a.target_speed = '0;
    for (int k = 1; k <= 5; k++) step("a_to0", 1'b0, 20 - 4 * k, 1, (k == 5) ? 1 : 0, 0);
    bus_a.target_speed = 10'sd10;
    step("a_10_1", 1'b0, 4, 1, 0, 0);
    step("a_10_2", 1'b0, 8, 1, 0, 0);
    step("a_10_3", 1'b0, 10, 1, 1, 0);
    for (int k = 0; k < 3; k++) step("a_10_hold", 1'b0, 10, 1, 1, 0);
    bus_a.target_speed = 10'sd20;
    step("a_20_1", 1'b0, 14, 1, 0, 0);
    step("a_20_2", 1'b0, 18, 1, 0, 0);
    step("a_20_3", 1'b0, 20, 1, 1, 0);

    // Reversal +20 -> -8 through zero and a two-tick dwell.
    bus_a.target_speed = -10'sd8;
    for (int k = 1; k <= 4; k++) step("a_rv_down", 1'b0, 20 - 4 * k, 1, 0, 0);
    step("a_rv_zero", 1'b0, 0, 1, 0, 1);
    step("a_rv_dwell", 1'b0, 0, 1, 0, 1);
    step("a_rv_flip", 1'b0, 0, 0, 0, 0);
    step("a_rv_up1", 1'b0, 4, 0, 0, 0);
    step("a_rv_up2", 1'b0, 8, 0, 1, 0);

    // Reach 40 reverse, then drop enable: ramp to 0 and idle, dir held.
    bus_a.target_speed = -10'sd40;
    for (int k = 1; k <= 8; k++) step("a_40", 1'b0, 8 + 4 * k, 0, (k == 8) ? 1 : 0, 0);
    bus_a.enable = 1'b0;
    for (int k = 1; k <= 10; k++) step("a_off", 1'b0, 40 - 4 * k, 0, 0, 0);
    step("a_idle", 1'b0, 0, 0, 0, 0);
    bus_a.enable = 1'b1;
    step("a_on", 1'b0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) step("a_reup", 1'b0, 4 * k, 0, (k == 10) ? 1 : 0, 0);

    // Reversal request, then enable low during the dwell: abort, dir kept.
    bus_a.target_speed = 10'sd8;
    for (int k = 1; k <= 9; k++) step("a_ab_down", 1'b0, 40 - 4 * k, 0, 0, 0);
    step("a_ab_dwell", 1'b0, 0, 0, 0, 1);
    bus_a.enable = 1'b0;
    step("a_ab_abort", 1'b0, 0, 0, 0, 0);
    step("a_ab_idle", 1'b0, 0, 0, 0, 0);
    step("a_ab_stay", 1'b0, 0, 0, 0, 0);

    // Mid-ramp toward -400, then a one-cycle reset at speed 200.
    bus_a.enable       = 1'b1;
    bus_a.target_speed = -10'sd400;
    step("a_mr_on", 1'b0, 0, 0, 0, 0);
    for (int k = 1; k < 50; k++) next_tick();
    step("a_mr_200", 1'b0, 200, 0, 0, 0);
    reset_n            = 1'b0;
    bus_a.target_speed = '0;
    @(posedge clk);
    #1;
    check_out("a_rst", 1'b0, 0, 1, 0, 0);
    reset_n = 1'b1;
    // Zero target with enable makes the first tick visible as at_target.
    for (int k = 1; k < TDIV; k++) begin
      @(posedge clk);
      #1;
      check("a_rst_wait.at_target", int'(bus_a.at_target), 0);
    end
    @(posedge clk);
    #1;
    check_out("a_rst_first", 1'b0, 0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
